vga_vram_ctrl: RTL and testbench

- Responder side of the VGA VRAM read interface: the display controller issues pixel reads, and this block serves them from external async 16-bit SRAM (DE2-class, 256Kx16).
- Also accepts pixel writes from the core (drawing engine / CPU) into a small write FIFO and retires them into SRAM whenever no display read is pending.
- Sits in the clk_core domain between the VGA controller's VRAM port and the board SRAM pins.

---
 rtl/vga_vram_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_vga_vram_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_ctrl.sv
// VGA VRAM responder: serves display pixel reads from async 16-bit SRAM and retires
// buffered core pixel writes when no read is pending. Optional fill engine: VRAM_CLEAR_EN.
module vga_vram_ctrl #(
    parameter int unsigned PWIDTH      = 8,
    parameter int unsigned AWIDTH      = 19,
    parameter int unsigned SWIDTH      = 16,
    parameter int unsigned WFIFO_DEPTH = 8
) (
    input  logic              clk_core,
    input  logic              rst_core,
    input  logic              vram_rd,
    input  logic [AWIDTH-1:0] vram_addr,
    output logic              vram_busy,
    output logic [PWIDTH-1:0] vram_data,
    output logic              vram_vld,
    input  logic              wr_req,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [PWIDTH-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_idle,
`ifdef VRAM_CLEAR_EN
    input  logic              clr_start,
    input  logic [PWIDTH-1:0] clr_color,
    output logic              clr_busy,
`endif
    output logic [AWIDTH-2:0] sram_addr,
    input  logic [SWIDTH-1:0] sram_dq_i,
    output logic [SWIDTH-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int unsigned PTRW = $clog2(WFIFO_DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam int unsigned REP  = SWIDTH / PWIDTH;

    typedef enum logic [1:0] {StIdle, StRead, StWrSetup, StWrPulse} state_e;

    state_e            state_q;
    logic              rd_lsb_q;

    logic [AWIDTH-1:0] fifo_addr [WFIFO_DEPTH];
    logic [PWIDTH-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTRW-1:0]   wptr_q, rptr_q;
    logic [CNTW-1:0]   count_q;

    logic              fifo_full, fifo_nempty;
    logic              push, pop, arb, wr_avail, wr_go;
    logic [AWIDTH-1:0] head_addr;
    logic [PWIDTH-1:0] head_data;

    assign fifo_full   = (count_q == CNTW'(WFIFO_DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign head_addr   = fifo_addr[rptr_q];
    assign head_data   = fifo_data[rptr_q];

    assign arb   = (state_q == StIdle) || (state_q == StRead);
    assign pop   = arb && !vram_rd && fifo_nempty;
    assign wr_go = arb && !vram_rd && wr_avail;
    assign push  = wr_req && wr_ready;

    assign vram_busy = (state_q == StWrSetup) || (state_q == StWrPulse);
    assign wr_idle   = !fifo_nempty && !vram_busy;
    assign sram_ce_n = 1'b0;

`ifdef VRAM_CLEAR_EN
    logic              clr_busy_q, clr_issued_q, wr_is_clr_q;
    logic [AWIDTH-2:0] clr_addr_q;
    logic [PWIDTH-1:0] clr_color_q;
    logic              clr_want;

    assign clr_want = clr_busy_q && !clr_issued_q;
    assign wr_avail = fifo_nempty || clr_want;
    assign wr_ready = !fifo_full && !clr_busy_q;
    assign clr_busy = clr_busy_q;

    // Fill engine; the FIFO keeps precedence so a write racing clr_start still retires in order.
    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            clr_busy_q   <= 1'b0;
            clr_issued_q <= 1'b0;
            wr_is_clr_q  <= 1'b0;
            clr_addr_q   <= '0;
            clr_color_q  <= '0;
        end else begin
            if (clr_start && wr_idle && !clr_busy_q) begin
                clr_busy_q   <= 1'b1;
                clr_issued_q <= 1'b0;
                clr_addr_q   <= '0;
                clr_color_q  <= clr_color;
            end
            if (wr_go) begin
                wr_is_clr_q <= !fifo_nempty;
                if (!fifo_nempty) begin
                    if (clr_addr_q == '1) clr_issued_q <= 1'b1;
                    else clr_addr_q <= clr_addr_q + 1'b1;
                end
            end
            if (state_q == StWrPulse && wr_is_clr_q && clr_issued_q) clr_busy_q <= 1'b0;
        end
    end
`else
    assign wr_avail = fifo_nempty;
    assign wr_ready = !fifo_full;
`endif

    always_ff @(posedge clk_core) begin
        if (push) begin
            fifo_addr[wptr_q] <= wr_addr;
            fifo_data[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            state_q    <= StIdle;
            rd_lsb_q   <= 1'b0;
            vram_vld   <= 1'b0;
            vram_data  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            vram_vld <= 1'b0;
            // SRAM data is valid by the end of the READ cycle; capture the addressed lane.
            if (state_q == StRead) begin
                vram_vld  <= 1'b1;
                vram_data <= rd_lsb_q ? sram_dq_i[2*PWIDTH-1:PWIDTH] : sram_dq_i[PWIDTH-1:0];
            end
            unique case (state_q)
                StIdle, StRead: begin
                    if (vram_rd) begin
                        state_q    <= StRead;
                        sram_addr  <= vram_addr[AWIDTH-1:1];
                        rd_lsb_q   <= vram_addr[0];
                        sram_oe_n  <= 1'b0;
                        sram_ub_n  <= 1'b0;
                        sram_lb_n  <= 1'b0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else if (wr_avail) begin
                        state_q    <= StWrSetup;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b1;
                        sram_we_n  <= 1'b1;
                        if (fifo_nempty) begin
                            sram_addr <= head_addr[AWIDTH-1:1];
                            sram_dq_o <= {REP{head_data}};
                            sram_ub_n <= ~head_addr[0];
                            sram_lb_n <= head_addr[0];
                        end
`ifdef VRAM_CLEAR_EN
                        else begin
                            sram_addr <= clr_addr_q;
                            sram_dq_o <= {REP{clr_color_q}};
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                        end
`endif
                    end else begin
                        state_q    <= StIdle;
                        sram_oe_n  <= 1'b1;
                        sram_ub_n  <= 1'b1;
                        sram_lb_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end
                end
                StWrSetup: begin
                    state_q   <= StWrPulse;
                    sram_we_n <= 1'b0;
                end
                StWrPulse: begin
                    // Always pass through IDLE so the bus turns around before the next access.
                    state_q    <= StIdle;
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_vram_ctrl.sv
// Bench for vga_vram_ctrl: behavioural SRAM, read/write scoreboards checked at negedge.
module tb_vga_vram_ctrl;
`ifdef VRAM_CLEAR_EN
    localparam int AW = 5;
`else
    localparam int AW = 19;
`endif
    localparam int WD = 1 << (AW - 1);

    logic          clk_core = 1'b0;
    logic          rst_core = 1'b1;
    logic          vram_rd = 1'b0;
    logic [AW-1:0] vram_addr = '0;
    logic          vram_busy, vram_vld;
    logic [7:0]    vram_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_ready, wr_idle;
    logic [AW-2:0] sram_addr;
    logic [15:0]   sram_dq_i, sram_dq_o;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef VRAM_CLEAR_EN
    logic          clr_start = 1'b0;
    logic [7:0]    clr_color = '0;
    logic          clr_busy;
`endif

    always #5 clk_core = ~clk_core;

    vga_vram_ctrl #(.PWIDTH(8), .AWIDTH(AW), .SWIDTH(16), .WFIFO_DEPTH(8)) dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr),
        .vram_busy (vram_busy),
        .vram_data (vram_data),
        .vram_vld  (vram_vld),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .wr_idle   (wr_idle),
`ifdef VRAM_CLEAR_EN
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
`endif
        .sram_addr (sram_addr),
        .sram_dq_i (sram_dq_i),
        .sram_dq_o (sram_dq_o),
        .sram_dq_oe(sram_dq_oe),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    // Behavioural async SRAM sampled on the core clock.
    logic [15:0] sram_mem [WD];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;
    always @(posedge clk_core) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) sram_mem[sram_addr][7:0] = sram_dq_o[7:0];
            if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq_o[15:8];
        end
    end

    typedef struct { logic [7:0] d; int due; } rd_exp_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_exp_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int acc_cnt = 0;
    int busy_seen = 0;
    logic busy_watch = 1'b0;
    rd_exp_t rd_q[$];
    wr_exp_t wq[$];
    int pulse_cyc[$];
    rd_exp_t rd_e, rd_n;
    wr_exp_t wr_e, wr_n;
    logic [15:0] mon_w;
    logic [AW-2:0] clr_exp_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    always @(posedge clk_core) cyc++;

    always @(negedge clk_core) begin
        if (rst_core) begin
            if (vram_vld) begin
                vld_cnt++;
                if (rd_q.size() == 0) check("rd_unexpected", 64'(1), 64'(0));
                else begin
                    rd_e = rd_q.pop_front();
                    check("rd_data", 64'(vram_data), 64'(rd_e.d));
                    check("rd_latency", 64'(cyc), 64'(rd_e.due));
                end
            end
            if (vram_rd && !vram_busy) begin
                mon_w = sram_mem[vram_addr[AW-1:1]];
                rd_n.d = vram_addr[0] ? mon_w[15:8] : mon_w[7:0];
                rd_n.due = cyc + 2;
                rd_q.push_back(rd_n);
            end
            if (busy_watch && vram_busy) busy_seen++;
            if (!sram_we_n) begin
                pulse_cyc.push_back(cyc);
`ifdef VRAM_CLEAR_EN
                check("clr_bus", 64'({sram_addr, sram_dq_o, sram_ub_n, sram_lb_n, sram_oe_n,
                                      sram_dq_oe}),
                      64'({clr_exp_addr, 8'h1F, 8'h1F, 4'b0011}));
                clr_exp_addr = clr_exp_addr + 1'b1;
`else
                if (wq.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
                else begin
                    wr_e = wq.pop_front();
                    check("wr_bus", 64'({sram_addr, sram_dq_o, sram_ub_n, sram_lb_n, sram_oe_n,
                                         sram_dq_oe}),
                          64'({wr_e.a[AW-1:1], wr_e.d, wr_e.d, ~wr_e.a[0], wr_e.a[0], 2'b11}));
                end
`endif
            end
            if (wr_req && wr_ready) begin
                acc_cnt++;
                wr_n.a = wr_addr;
                wr_n.d = wr_data;
                wq.push_back(wr_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_ctrl", 64'({vram_vld, vram_busy, wr_ready, wr_idle, sram_ce_n, sram_oe_n,
                               sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}),
              64'(10'b0011011110));
        check("rst_vram_data", 64'(vram_data), 64'(0));
        check("rst_sram_addr", 64'(sram_addr), 64'(0));
    endtask

`ifndef VRAM_CLEAR_EN
    task automatic wait_idle(input int maxc, output int rise);
        int n;
        n = 0;
        @(negedge clk_core);
        while (!wr_idle && n < maxc) begin
            @(negedge clk_core);
            n++;
        end
        check("idle_timeout", 64'(n < maxc), 64'(1));
        rise = cyc;
    endtask

    task automatic check_pix(input string tag, input logic [AW-1:0] a, input logic [7:0] d);
        logic [15:0] w;
        w = sram_mem[a[AW-1:1]];
        check(tag, 64'(a[0] ? w[15:8] : w[7:0]), 64'(d));
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_req = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL sim_timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        int rise, drop, n;
        for (int i = 0; i < WD; i++) sram_mem[i] = pat(i);
        #2 rst_core = 1'b0;
        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        check_reset_vals();
`ifdef VRAM_CLEAR_EN
        check("rst_clr_busy", 64'(clr_busy), 64'(0));
`endif
        tick();
        rst_core = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_core);
            check("idle_bus", 64'({sram_we_n, sram_dq_oe, vram_busy, wr_idle}), 64'(4'b1001));
        end
        tick();

`ifndef VRAM_CLEAR_EN
        // Single reads: both lanes of a preloaded word.
        sram_mem[16] = 16'hA55A;
        vram_rd = 1'b1;
        vram_addr = AW'(32'h21);
        tick();
        vram_addr = AW'(32'h20);
        tick();
        vram_rd = 1'b0;
        @(negedge clk_core);
        check("rd_hi", 64'({vram_vld, vram_data}), 64'({1'b1, 8'hA5}));
        @(negedge clk_core);
        check("rd_lo", 64'({vram_vld, vram_data}), 64'({1'b1, 8'h5A}));
        @(negedge clk_core);
        check("rd_hold", 64'({vram_vld, vram_data}), 64'({1'b0, 8'h5A}));
        tick();

        // Three writes, no reads: 3-cycle spacing.
        pulse_cyc.delete();
        push_wr(AW'(32'h4), 8'hFF);
        push_wr(AW'(32'h5), 8'h11);
        push_wr(AW'(32'h100), 8'h3C);
        wr_req = 1'b0;
        wait_idle(100, rise);
        check("w3_pulses", 64'(pulse_cyc.size()), 64'(3));
        if (pulse_cyc.size() == 3) begin
            check("w3_space0", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(3));
            check("w3_space1", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'(3));
            check("w3_idle_rise", 64'(rise), 64'(pulse_cyc[2] + 1));
        end
        check("w3_word2", 64'(sram_mem[2]), 64'(16'h11FF));
        check("w3_word80", 64'(sram_mem[32'h80]), 64'({pat(32'h80) >> 8, 8'h3C}));
        tick();

        // Continuous reads starve 4 queued writes.
        pulse_cyc.delete();
        vld_cnt = 0;
        busy_seen = 0;
        busy_watch = 1'b1;
        for (int i = 0; i < 64; i++) begin
            vram_rd = 1'b1;
            vram_addr = AW'(32'h1000 + i * 3);
            wr_req = (i < 4);
            wr_addr = AW'(32'h3000 + i);
            wr_data = 8'(8'h80 + i);
            tick();
        end
        vram_rd = 1'b0;
        wr_req = 1'b0;
        drop = cyc;
        busy_watch = 1'b0;
        wait_idle(100, rise);
        repeat (3) tick();
        check("starve_busy", 64'(busy_seen), 64'(0));
        check("starve_vld", 64'(vld_cnt), 64'(64));
        check("starve_pulses", 64'(pulse_cyc.size()), 64'(4));
        if (pulse_cyc.size() > 0) check("starve_first_wr", 64'(pulse_cyc[0]), 64'(drop + 2));
        for (int i = 0; i < 4; i++) check_pix("starve_pix", AW'(32'h3000 + i), 8'(8'h80 + i));

        // Fill the FIFO behind continuous reads; 9th write refused; pointers wrap.
        pulse_cyc.delete();
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            vram_rd = 1'b1;
            vram_addr = AW'(32'h4000 + i);
            push_wr(AW'(32'h5000 + i * 7), 8'(8'h40 + i));
        end
        wr_addr = AW'(32'h6000);
        wr_data = 8'h99;
        @(negedge clk_core);
        check("full_ready", 64'(wr_ready), 64'(0));
        repeat (3) tick();
        wr_req = 1'b0;
        check("full_accepts", 64'(acc_cnt), 64'(8));
        vram_rd = 1'b0;
        wait_idle(100, rise);
        check("full_pulses", 64'(pulse_cyc.size()), 64'(8));
        for (int i = 0; i < 8; i++) check_pix("full_pix", AW'(32'h5000 + i * 7), 8'(8'h40 + i));
        check("full_9th_dropped", 64'(sram_mem[32'h3000]), 64'(pat(32'h3000)));
        push_wr(AW'(32'h7000), 8'h5A);
        push_wr(AW'(32'h7001), 8'hA5);
        wr_req = 1'b0;
        wait_idle(100, rise);
        check("wrap_word", 64'(sram_mem[32'h3800]), 64'(16'hA55A));

        // Reset during a write pulse.
        push_wr(AW'(32'h7100), 8'h11);
        push_wr(AW'(32'h7103), 8'h22);
        wr_req = 1'b0;
        n = 0;
        @(negedge clk_core);
        while (sram_we_n && n < 20) begin
            @(negedge clk_core);
            n++;
        end
        check("rst_pulse_seen", 64'(n < 20), 64'(1));
        rst_core = 1'b0;
        #1;
        check("rst_mid_wr", 64'({sram_we_n, sram_dq_oe, wr_idle, wr_ready}), 64'(4'b1011));
        wq.delete();
        rd_q.delete();
        tick();
        rst_core = 1'b1;
        pulse_cyc.delete();
        repeat (10) tick();
        check("rst_no_retire", 64'(pulse_cyc.size()), 64'(0));
        check("rst_word_kept", 64'(sram_mem[32'h3880]), 64'(pat(32'h3880)));
        check("rst_word_kept2", 64'(sram_mem[32'h3881]), 64'(pat(32'h3881)));
`else
        // Fill engine with interleaved reads; a second clr_start mid-fill is ignored.
        pulse_cyc.delete();
        clr_color = 8'h1F;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_color = 8'h00;
        @(negedge clk_core);
        check("clr_started", 64'({clr_busy, wr_ready}), 64'(2'b10));
        for (int i = 0; i < 40; i++) begin
            vram_rd = (i % 3 == 0);
            vram_addr = AW'(i * 7);
            clr_start = (i == 10);
            tick();
        end
        vram_rd = 1'b0;
        clr_start = 1'b0;
        n = 0;
        @(negedge clk_core);
        while (clr_busy && n < 300) begin
            @(negedge clk_core);
            n++;
        end
        check("clr_timeout", 64'(n < 300), 64'(1));
        drop = cyc;
        check("clr_pulses", 64'(pulse_cyc.size()), 64'(16));
        if (pulse_cyc.size() > 0) check("clr_busy_fall", 64'(drop), 64'(pulse_cyc[$] + 1));
        for (int i = 0; i < WD; i++) check("clr_word", 64'(sram_mem[i]), 64'(16'h1F1F));
        repeat (3) tick();
        check("clr_ready_back", 64'({clr_busy, wr_ready, wr_idle}), 64'(3'b011));
        rise = 0;
`endif
        repeat (3) tick();
        check("rd_queue_drained", 64'(rd_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
